// File: rtl/life_ctrl_pkg.sv
// Shared types and default geometry for the life_engine pass sequencer.
package life_ctrl_pkg;

    localparam int unsigned ROWS  = 128;
    localparam int unsigned RBITS = 7;

    typedef enum logic [1:0] {IDLE, LOAD, PASS, DRAIN} ctrl_state_t;

    typedef logic [RBITS-1:0] row_idx_t;

endpackage

// File: rtl/life_wr_align.sv
// Write-side delay line: carries {valid,row} from a pass read to the cycle its output row is written.
module life_wr_align #(
    parameter int unsigned WLAT  = 4,
    parameter int unsigned RBITS = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [RBITS-1:0] in_row,
    output logic             out_valid,
    output logic [RBITS-1:0] out_row
);

    logic [WLAT-1:0]  vld;
    logic [RBITS-1:0] row [WLAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int unsigned i = 0; i < WLAT; i++) row[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            row[0] <= in_row;
            for (int unsigned i = 1; i < WLAT; i++) begin
                vld[i] <= vld[i-1];
                row[i] <= row[i-1];
            end
        end
    end

    assign out_valid = vld[WLAT-1];
    assign out_row   = row[WLAT-1];

endmodule

// File: rtl/life_pass_ctrl.sv
// Initiator-side sequencer for life_engine: image load, toroidal generation passes
// between two memory banks, and single-row video reads.
module life_pass_ctrl
    import life_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 256,
    parameter int unsigned DEPTH   = 2 * ROWS,
    parameter int unsigned DBITS   = RBITS + 1,
    parameter int unsigned GENS    = 1,
    parameter int unsigned WLAT    = 4,
    parameter int unsigned VID_LAT = 3,
    parameter int unsigned NPW     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NPW-1:0]   npass,
    input  logic             init_start,
    input  logic             init_valid,
    input  logic [WIDTH-1:0] init_row,
    output logic             init_ready,
    input  logic             vid_req,
    input  logic [DBITS-2:0] vid_row,
    output logic             vid_ack,
    output logic             vid_valid,
    output logic             busy,
    output logic             done,
    output logic             bank,
    output logic [DBITS-1:0] raddr,
    output logic [DBITS-1:0] waddr,
    output logic             we,
    output logic             sh,
    output logic             ld,
    output logic             init,
    output logic [WIDTH-1:0] init_data
);

    localparam int unsigned RW    = DBITS - 1;
    localparam int unsigned NROWS = DEPTH / 2;
    localparam int unsigned CW    = RW + 2;
    localparam logic [CW-1:0] LAST_RD  = CW'(NROWS + 2 * GENS - 1);
    localparam logic [CW-1:0] FIRST_WR = CW'(2 * GENS);
    localparam logic [RW-1:0] LAST_ROW = RW'(NROWS - 1);

    ctrl_state_t         state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [NPW-1:0]      pass_cnt, pass_d;
    logic                bank_d, done_d;
    logic [VID_LAT-1:0]  vid_pipe;
    logic                load_we;
    logic                wa_in_valid, wa_valid;
    logic [RW-1:0]       wa_in_row, wa_row;

    life_wr_align #(
        .WLAT  (WLAT),
        .RBITS (RW)
    ) u_wr_align (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (wa_in_valid),
        .in_row    (wa_in_row),
        .out_valid (wa_valid),
        .out_row   (wa_row)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pass_cnt <= '0;
            bank     <= 1'b0;
            done     <= 1'b0;
            vid_pipe <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pass_cnt    <= pass_d;
            bank        <= bank_d;
            done        <= done_d;
            vid_pipe[0] <= ld;
            for (int unsigned i = 1; i < VID_LAT; i++) vid_pipe[i] <= vid_pipe[i-1];
        end
    end

    assign vid_valid = vid_pipe[VID_LAT-1];

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        pass_d      = pass_cnt;
        bank_d      = bank;
        done_d      = 1'b0;
        raddr       = '0;
        sh          = 1'b0;
        ld          = 1'b0;
        vid_ack     = 1'b0;
        init        = 1'b0;
        init_ready  = 1'b0;
        load_we     = 1'b0;
        wa_in_valid = 1'b0;
        wa_in_row   = '0;

        unique case (state)
            IDLE: begin
                if (init_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (start) begin
                    if (npass == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = PASS;
                        cnt_d   = '0;
                        pass_d  = npass;
                    end
                end else if (vid_req) begin
                    ld      = 1'b1;
                    vid_ack = 1'b1;
                    raddr   = {bank, vid_row};
                end
            end
            LOAD: begin
                init       = 1'b1;
                init_ready = 1'b1;
                if (init_valid) begin
                    load_we = 1'b1;
                    cnt_d   = cnt + 1'b1;
                    if (cnt[RW-1:0] == LAST_ROW) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            PASS: begin
                // Read index i fetches row (i-GENS) mod ROWS; the first 2*GENS reads only prime the engine.
                sh          = 1'b1;
                raddr       = {bank, cnt[RW-1:0] - RW'(GENS)};
                wa_in_valid = (cnt >= FIRST_WR);
                wa_in_row   = cnt[RW-1:0] - RW'(2 * GENS);
                cnt_d       = cnt + 1'b1;
                if (cnt == LAST_RD) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (wa_valid && wa_row == LAST_ROW) begin
                    bank_d = ~bank;
                    pass_d = pass_cnt - 1'b1;
                    if (pass_cnt == NPW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PASS;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        we = load_we | wa_valid;
        if (load_we)       waddr = {bank, cnt[RW-1:0]};
        else if (wa_valid) waddr = {~bank, wa_row};
        else               waddr = '0;

        init_data = init ? init_row : '0;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_life_pass_ctrl.sv
// Randomized bench for life_pass_ctrl with a behavioural engine/memory model and a torus Life reference.
module tb_life_pass_ctrl;
    import life_ctrl_pkg::*;

    localparam int W    = 256;
    localparam int NR   = 128;
    localparam int G    = 1;
    localparam int WL   = 4;
    localparam int VL   = 3;

    logic           clk = 1'b0;
    logic           reset, start, init_start, init_valid, vid_req;
    logic [15:0]    npass;
    logic [W-1:0]   init_row;
    logic [6:0]     vid_row;
    logic           init_ready, vid_ack, vid_valid, busy, done, bank, we, sh, ld, init;
    logic [7:0]     raddr, waddr;
    logic [W-1:0]   init_data;

    life_pass_ctrl #(
        .WIDTH(W), .DEPTH(2*NR), .DBITS(8), .GENS(G), .WLAT(WL), .VID_LAT(VL), .NPW(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .npass(npass),
        .init_start(init_start), .init_valid(init_valid), .init_row(init_row),
        .init_ready(init_ready), .vid_req(vid_req), .vid_row(vid_row),
        .vid_ack(vid_ack), .vid_valid(vid_valid), .busy(busy), .done(done),
        .bank(bank), .raddr(raddr), .waddr(waddr), .we(we), .sh(sh), .ld(ld),
        .init(init), .init_data(init_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] life_row(input logic [W-1:0] a, c, b);
        logic [W-1:0] r;
        int l, rr, n;
        for (int x = 0; x < W; x++) begin
            l  = (x + W - 1) % W;
            rr = (x + 1) % W;
            n  = 0;
            n += a[l] + a[x] + a[rr] + c[l] + c[rr] + b[l] + b[x] + b[rr];
            r[x] = (n == 3) || (c[x] && n == 2);
        end
        return r;
    endfunction

    // Golden image and behavioural model of engine memory.
    logic [W-1:0] img [NR];
    logic [W-1:0] mem [256];

    task automatic golden_step();
        logic [W-1:0] t [NR];
        for (int r = 0; r < NR; r++)
            t[r] = life_row(img[(r + NR - 1) % NR], img[r], img[(r + 1) % NR]);
        img = t;
    endtask

    typedef struct { logic [W-1:0] data; int due; int row; } wr_t;
    wr_t          pipe[$];
    logic [W-1:0] win[$];
    int           vq[$];
    int           cyc = 0;
    int           rd_idx = 0;
    int           rd_total = 0;
    int           last_wr_cyc = 0;
    logic         sh_prev = 1'b0;
    logic         exp_bank = 1'b0;
    row_idx_t     ld_row = '0;
    logic         mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (mon_en) begin
        wr_t      e;
        row_idx_t er;
        chk("bank", bank, exp_bank);
        chk("we_ld_excl", we & ld, 0);
        chk("ld_idle", ld & busy, 0);
        if (init && !init_valid) chk("stall_we", we, 0);
        if (we && init) begin
            chk("load_addr", waddr, {exp_bank, ld_row});
            chk("load_data", init_data, init_row);
            mem[waddr] = init_data;
            ld_row++;
        end
        if (sh) begin
            if (!sh_prev) rd_idx = 0;
            er = row_idx_t'((rd_idx + NR - G) % NR);
            chk("rd_addr", raddr, {exp_bank, er});
            win.push_back(mem[raddr]);
            if (win.size() > 3) void'(win.pop_front());
            if (rd_idx >= 2*G) pipe.push_back('{life_row(win[0], win[1], win[2]), cyc + WL, rd_idx - 2*G});
            rd_idx++;
            rd_total++;
        end else if (sh_prev) begin
            chk("rd_count", rd_idx, NR + 2*G);
        end
        if (we && !init) begin
            if (pipe.size() == 0) chk("wr_unexpected", we, 0);
            else begin
                e  = pipe.pop_front();
                er = row_idx_t'(e.row);
                chk("wr_lat", cyc, e.due);
                chk("wr_addr", waddr, {~exp_bank, er});
                mem[waddr] = e.data;
                if (e.row == NR - 1) begin
                    exp_bank    = ~exp_bank;
                    last_wr_cyc = cyc;
                end
            end
        end
        if (ld) begin
            chk("vid_addr", raddr, {exp_bank, vid_row});
            chk("vid_ack", vid_ack, 1);
            vq.push_back(cyc + VL);
        end
        if (vid_valid) begin
            if (vq.size() == 0) chk("vid_valid_spurious", vid_valid, 0);
            else chk("vid_lat", cyc, vq.pop_front());
        end
        sh_prev = sh;
        if (reset) begin
            pipe.delete(); win.delete(); vq.delete();
            exp_bank = 1'b0; ld_row = '0; sh_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_image();
        for (int r = 0; r < NR; r++)
            for (int w = 0; w < W/32; w++) img[r][32*w +: 32] = $urandom & $urandom;
    endtask

    task automatic load_image();
        int beat = 0;
        int k = 0;
        logic acc;
        init_start = 1'b1; step; init_start = 1'b0;
        while (beat < NR && k < 8*NR) begin
            init_valid = (k < 3) ? (k != 1) : ($urandom_range(0, 3) != 0);
            init_row   = img[beat];
            if (k == 0) chk("load_ready", init_ready, 1);
            acc = init_valid && init_ready;
            step;
            if (acc) beat++;
            k++;
        end
        init_valid = 1'b0; init_row = '0;
        chk("load_beats", beat, NR);
        chk("load_done", done, 1);
        chk("load_init_off", {init, busy}, 0);
        step;
        chk("load_done_pulse", done, 0);
    endtask

    task automatic compare_bank(input string tag);
        row_idx_t r7;
        for (int r = 0; r < NR; r++) begin
            r7 = row_idx_t'(r);
            chk(tag, mem[{exp_bank, r7}], img[r]);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step;
            if (done) found = 1'b1;
        end
        chk(tag, found, 1);
    endtask

    task automatic run_pass(input int n);
        int rd0 = rd_total;
        logic b0 = bank;
        npass = 16'(n); start = 1'b1; step; start = 1'b0;
        if (n == 0) begin
            chk("npass0_done", done, 1);
            chk("npass0_idle", {busy, sh}, 0);
            step;
            chk("npass0_pulse", done, 0);
            chk("npass0_reads", rd_total - rd0, 0);
            chk("npass0_bank", bank, b0);
        end else begin
            chk("pass_start_sh", sh, 1);
            wait_done("pass_done_seen", n * 400);
            chk("done_after_last_wr", cyc, last_wr_cyc + 1);
            chk("pass_reads", rd_total - rd0, n * (NR + 2*G));
            chk("pass_idle", busy, 0);
            repeat (n) golden_step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycles %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] hb;
        logic [7:0]   b8;
        reset = 1'b1; start = 1'b0; npass = '0; init_start = 1'b0; init_valid = 1'b0;
        init_row = '0; vid_req = 1'b0; vid_row = '0;
        repeat (3) step;
        chk("reset_outs", {busy, done, bank, we, sh, ld, init, init_ready, vid_ack, vid_valid, raddr, waddr}, 0);
        chk("reset_init_data", init_data, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        step;

        // Counting pattern load with stalls.
        for (int r = 0; r < NR; r++) begin
            b8 = 8'(r);
            img[r] = {32{b8}};
        end
        load_image();
        compare_bank("load_mem");

        // Vertical blinker across rows 127/0/1 in column 0.
        img = '{default: '0};
        img[NR-1][0] = 1'b1; img[0][0] = 1'b1; img[1][0] = 1'b1;
        load_image();
        run_pass(1);
        chk("bank_after_pass", bank, 1);
        hb = '0; hb[W-1] = 1'b1; hb[0] = 1'b1; hb[1] = 1'b1;
        chk("blinker_row0", mem[8'd128], hb);
        chk("blinker_row1", mem[8'd129], 0);
        chk("blinker_row127", mem[8'd255], 0);
        compare_bank("blinker_mem");

        // Random soup, two generations.
        rand_image();
        load_image();
        run_pass(2);
        chk("bank_after_2", bank, 1);
        compare_bank("npass2_mem");

        run_pass(0);

        // Video request and a stray start during a pass.
        npass = 16'd1; start = 1'b1; step; start = 1'b0;
        repeat (20) step;
        vid_req = 1'b1; vid_row = 7'($urandom);
        npass = 16'd3; start = 1'b1; step; start = 1'b0;
        wait_done("vid_pass_done", 400);
        chk("vid_first_ack", vid_ack, 1);
        for (int i = 0; i < 4; i++) begin
            step;
            vid_row = 7'($urandom);
        end
        step;
        vid_req = 1'b0;
        repeat (6) step;
        chk("vid_stray_start", busy, 0);
        chk("vid_drained", vq.size(), 0);
        golden_step();
        compare_bank("vid_pass_mem");

        // Reset in the middle of a pass.
        npass = 16'd1; start = 1'b1; step; start = 1'b0;
        repeat (50) step;
        chk("rd_idx50_addr", raddr, {bank, 7'd49});
        reset = 1'b1; step;
        chk("midreset_outs", {busy, done, bank, we, sh, ld, init, init_ready, vid_ack, vid_valid, raddr, waddr}, 0);
        reset = 1'b0; step;
        repeat (6) step;
        chk("midreset_quiet", {we, busy}, 0);
        rand_image();
        load_image();
        run_pass(1);
        compare_bank("post_reset_mem");

        repeat (8) step;
        chk("wr_drained", pipe.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
